// File: rtl/udc_bus_collect_if.sv
// Byte-stream input and LinkUdc output bundle of the DC-link voltage collector.
interface udc_bus_collect_if #(
   parameter int unsigned N_MOD = 24
);
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  clear_fresh;
   logic [16*N_MOD-1:0]   link_udc_bus;
   logic                  frame_ok;
   logic                  frame_err;
   logic [15:0]           err_cnt;
   logic [N_MOD-1:0]      fresh_mask;
   logic                  all_fresh_c;

   modport master (
      output rx_valid, rx_data, clear_fresh,
      input  link_udc_bus, frame_ok, frame_err, err_cnt, fresh_mask, all_fresh_c
   );

   modport slave (
      input  rx_valid, rx_data, clear_fresh,
      output link_udc_bus, frame_ok, frame_err, err_cnt, fresh_mask, all_fresh_c
   );
endinterface

// File: rtl/udc_bus_collect.sv
// Decodes per-module Udc report frames and writes them into the packed LinkUdc bus
// (module 1 in the MSB slice).
module udc_bus_collect #(
   parameter int unsigned N_MOD       = 24,
   parameter logic [7:0]  HEADER      = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 5000
) (
   input logic             i_clk,
   input logic             i_reset_n,
   udc_bus_collect_if.slave bus
);
   localparam int unsigned BUS_W = 16 * N_MOD;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {S_IDLE, S_ID, S_HI, S_LO, S_CHK} state_t;

   state_t            state;
   logic [7:0]        id_q;
   logic [7:0]        hi_q;
   logic [7:0]        lo_q;
   logic [TO_W-1:0]   to_cnt;
   logic [BUS_W-1:0]  udc_q;
   logic [N_MOD-1:0]  fresh_q;
   logic [15:0]       err_cnt_q;
   logic              ok_q;
   logic              err_q;

   logic [7:0]        sum_c;
   logic              good_c;

   // Frame check evaluated against the CHK byte currently on the bus
   assign sum_c  = 8'(id_q + hi_q + lo_q);
   assign good_c = (bus.rx_data == sum_c) && (id_q != 8'd0) && (32'(id_q) <= N_MOD);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= S_IDLE;
         id_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         to_cnt    <= '0;
         udc_q     <= '0;
         fresh_q   <= '0;
         err_cnt_q <= '0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         ok_q  <= 1'b0;
         err_q <= 1'b0;
         // Clear first; an accepted frame later in this block re-sets its own bit
         if (bus.clear_fresh) fresh_q <= '0;

         if (state == S_IDLE) begin
            to_cnt <= '0;
            if (bus.rx_valid && bus.rx_data == HEADER) state <= S_ID;
         end else if (bus.rx_valid) begin
            to_cnt <= '0;
            unique case (state)
               S_ID: begin
                  id_q  <= bus.rx_data;
                  state <= S_HI;
               end
               S_HI: begin
                  hi_q  <= bus.rx_data;
                  state <= S_LO;
               end
               S_LO: begin
                  lo_q  <= bus.rx_data;
                  state <= S_CHK;
               end
               default: begin
                  state <= S_IDLE;
                  if (good_c) begin
                     ok_q <= 1'b1;
                     for (int unsigned k = 1; k <= N_MOD; k++) begin
                        if (id_q == 8'(k)) begin
                           udc_q[16*(N_MOD-k) +: 16] <= {hi_q, lo_q};
                           fresh_q[k-1]              <= 1'b1;
                        end
                     end
                  end else begin
                     err_q <= 1'b1;
                     if (err_cnt_q != 16'hFFFF) err_cnt_q <= 16'(err_cnt_q + 16'd1);
                  end
               end
            endcase
         end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            // Link went quiet mid-frame: drop the partial frame
            state  <= S_IDLE;
            to_cnt <= '0;
            err_q  <= 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= 16'(err_cnt_q + 16'd1);
         end else begin
            to_cnt <= TO_W'(to_cnt + TO_W'(1));
         end
      end
   end

   assign bus.link_udc_bus = udc_q;
   assign bus.frame_ok     = ok_q;
   assign bus.frame_err    = err_q;
   assign bus.err_cnt      = err_cnt_q;
   assign bus.fresh_mask   = fresh_q;
   assign bus.all_fresh_c  = &fresh_q;
endmodule

// File: tb/tb_udc_bus_collect.sv
// Scoreboard bench for udc_bus_collect: stimulus pushes expected pulse snapshots, a monitor pops them.
module tb_udc_bus_collect;
   localparam int unsigned N  = 24;
   localparam int unsigned BW = 16 * N;

   typedef struct {
      bit               is_ok;
      logic [BW-1:0]    bus_v;
      logic [N-1:0]     mask;
      logic [15:0]      cnt;
   } exp_t;

   logic clk;
   logic rst_n;
   udc_bus_collect_if #(.N_MOD(N)) bus ();

   udc_bus_collect #(.N_MOD(N), .HEADER(8'hA5), .TIMEOUT_CYC(5000)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   exp_t        q[$];

   logic [15:0]  slot [1:N];
   logic [N-1:0] m_mask;
   logic [15:0]  m_cnt;

   task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      else n_pass++;
   endtask

   function automatic logic [BW-1:0] model_bus();
      logic [BW-1:0] r;
      r = '0;
      for (int k = 1; k <= N; k++) r[16*(N-k) +: 16] = slot[k];
      return r;
   endfunction

   task automatic push_exp(input bit is_ok);
      exp_t e;
      e.is_ok = is_ok;
      e.bus_v = model_bus();
      e.mask  = m_mask;
      e.cnt   = m_cnt;
      q.push_back(e);
   endtask

   task automatic send(input logic [7:0] b, input bit clr);
      bus.rx_valid    = 1'b1;
      bus.rx_data     = b;
      bus.clear_fresh = clr;
      @(posedge clk);
      #1;
      bus.rx_valid    = 1'b0;
      bus.clear_fresh = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] id, hi, lo, chk, input bit clr);
      send(8'hA5, 1'b0);
      send(id, 1'b0);
      send(hi, 1'b0);
      send(lo, 1'b0);
      send(chk, clr);
   endtask

   task automatic model_reset();
      for (int k = 1; k <= N; k++) slot[k] = 16'h0000;
      m_mask = '0;
      m_cnt  = 16'h0000;
   endtask

   // Monitor: every ok/err pulse must match the next queued expectation
   always @(negedge clk) begin
      if (rst_n && (bus.frame_ok || bus.frame_err)) begin
         if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_pulse ok=%b err=%b", bus.frame_ok, bus.frame_err);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("pulse_kind", BW'({bus.frame_ok, bus.frame_err}), BW'(e.is_ok ? 2'b10 : 2'b01));
            check("pulse_bus", bus.link_udc_bus, e.bus_v);
            check("pulse_mask", BW'(bus.fresh_mask), BW'(e.mask));
            check("pulse_err_cnt", BW'(bus.err_cnt), BW'(e.cnt));
            check("pulse_all_fresh", BW'(bus.all_fresh_c), BW'(&e.mask));
         end
      end
   end

   task automatic check_idle_outputs(input string nm);
      check({nm, "_bus"}, bus.link_udc_bus, model_bus());
      check({nm, "_mask"}, BW'(bus.fresh_mask), BW'(m_mask));
      check({nm, "_err_cnt"}, BW'(bus.err_cnt), BW'(m_cnt));
      check({nm, "_pulses"}, BW'({bus.frame_ok, bus.frame_err}), BW'(2'b00));
      check({nm, "_all_fresh"}, BW'(bus.all_fresh_c), BW'(&m_mask));
   endtask

   initial begin
      logic [7:0] c;
      bus.rx_valid    = 1'b0;
      bus.rx_data     = 8'h00;
      bus.clear_fresh = 1'b0;
      rst_n           = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First frame: module 1 lands in the MSB slice
      send_frame(8'h01, 8'h0C, 8'h80, 8'h8D, 1'b0);
      slot[1] = 16'h0C80; m_mask[0] = 1'b1; push_exp(1'b1);
      @(posedge clk); #1;
      check("slot1_msb", BW'(bus.link_udc_bus[383:368]), BW'(16'h0C80));

      // Module 24 lands in the LSB slice
      send_frame(8'h18, 8'h12, 8'h34, 8'h5E, 1'b0);
      slot[24] = 16'h1234; m_mask[23] = 1'b1; push_exp(1'b1);
      @(posedge clk); #1;
      check("slot24_lsb", BW'(bus.link_udc_bus[15:0]), BW'(16'h1234));

      // Fill modules 2..23 with value {id, 8'h55}
      for (int k = 2; k <= 23; k++) begin
         c = 8'(k + k + 8'h55);
         send_frame(8'(k), 8'(k), 8'h55, c, 1'b0);
         slot[k] = {8'(k), 8'h55}; m_mask[k-1] = 1'b1; push_exp(1'b1);
      end
      @(posedge clk); #1;
      check("all_fresh_set", BW'(bus.all_fresh_c), BW'(1'b1));

      // Clear mask; values stay
      bus.clear_fresh = 1'b1;
      @(posedge clk); #1;
      bus.clear_fresh = 1'b0;
      m_mask = '0;
      check_idle_outputs("after_clear");

      // Bad checksum, then ID 0
      send_frame(8'h03, 8'h01, 8'h00, 8'h00, 1'b0);
      m_cnt = 16'd1; push_exp(1'b0);
      send_frame(8'h00, 8'h01, 8'h00, 8'h01, 1'b0);
      m_cnt = 16'd2; push_exp(1'b0);
      @(posedge clk); #1;
      check_idle_outputs("after_rejects");

      // Timeout after 5000 idle clocks inside a frame
      send(8'hA5, 1'b0);
      send(8'h02, 1'b0);
      repeat (5000) @(posedge clk);
      m_cnt = 16'd3; push_exp(1'b0);
      @(posedge clk); #1;
      send_frame(8'h02, 8'h0A, 8'h00, 8'h0C, 1'b0);
      slot[2] = 16'h0A00; m_mask[1] = 1'b1; push_exp(1'b1);
      @(posedge clk); #1;
      check("slot2_after_timeout", BW'(bus.link_udc_bus[16*(N-2) +: 16]), BW'(16'h0A00));

      // Garbage ignored; clear coinciding with accept keeps only bit 4
      send(8'h00, 1'b0);
      send(8'hFF, 1'b0);
      send(8'h13, 1'b0);
      send_frame(8'h05, 8'h00, 8'h64, 8'h69, 1'b1);
      slot[5] = 16'h0064; m_mask = '0; m_mask[4] = 1'b1; push_exp(1'b1);
      @(posedge clk); #1;
      check("mask_clear_and_set", BW'(bus.fresh_mask), BW'(24'h000010));

      // Asynchronous reset mid-frame
      send(8'hA5, 1'b0);
      send(8'h07, 1'b0);
      send(8'h11, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_idle_outputs("async_reset");
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(8'h07, 8'h11, 8'h22, 8'h3A, 1'b0);
      slot[7] = 16'h1122; m_mask[6] = 1'b1; push_exp(1'b1);
      @(posedge clk); #1;
      check_idle_outputs("after_reset_frame");

      // Error counter saturation, starting near the top; ID 25 is out of range
      force dut.err_cnt_q = 16'hFFFD;
      @(posedge clk); #1;
      release dut.err_cnt_q;
      @(posedge clk); #1;
      send_frame(8'h19, 8'h00, 8'h00, 8'h19, 1'b0);
      m_cnt = 16'hFFFE; push_exp(1'b0);
      send_frame(8'h03, 8'h01, 8'h00, 8'h00, 1'b0);
      m_cnt = 16'hFFFF; push_exp(1'b0);
      send_frame(8'h03, 8'h01, 8'h00, 8'h00, 1'b0);
      m_cnt = 16'hFFFF; push_exp(1'b0);
      @(posedge clk); #1;
      check_idle_outputs("saturated");

      for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
      #1;
      check("queue_drained", BW'(q.size()), BW'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/udc_bus_collect.md
Name: udc_bus_collect

Overview:
Receives per-module DC-link voltage reports from the cascaded H-bridge power modules as a byte stream from the fiber UART front end. Decodes and checks each frame, then writes the reported voltage into a per-module register file. The register file is presented as the packed LinkUdc bus that the PWM calculation block consumes. This block is the writer side of the LinkUdc bus: module 1 occupies the MSB slice, matching the PWM block's unpacking order.

Parameters:
N_MOD, 24, number of modules; bus width is 16*N_MOD.
HEADER, 8'hA5, frame start byte.
TIMEOUT_CYC, 5000, maximum idle clocks between bytes inside a frame (100 us at 50 MHz).

Ports:
i_clk  in  1  system clock (50 MHz).
i_reset_n  in  1  asynchronous active-low reset.
i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle.
i_rx_data  in  8  received byte.
i_clear_fresh  in  1  one-cycle strobe; clears o_fresh_mask.
o_LinkUdc_BUS  out  16*N_MOD  packed module Udc; module k at [16*(N_MOD-k+1)-1 : 16*(N_MOD-k)].
o_frame_ok  out  1  one-cycle pulse per accepted frame.
o_frame_err  out  1  one-cycle pulse per rejected frame.
o_err_cnt  out  16  saturating count of rejected frames.
o_fresh_mask  out  N_MOD  bit k-1 set when module k has been updated since the last clear.
o_all_fresh  out  1  AND of o_fresh_mask.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low (i_reset_n).
- Reset values:
  - All Udc slots 16'h0000; o_LinkUdc_BUS = 0.
  - o_frame_ok = 0, o_frame_err = 0, o_err_cnt = 0, o_fresh_mask = 0, o_all_fresh = 0.
  - FSM in S_IDLE; timeout counter = 0.
- Frame format: HEADER, ID, UDC_HI, UDC_LO, CHK. The frame is valid when CHK == (ID + UDC_HI + UDC_LO) mod 256 and 1 <= ID <= N_MOD.
- FSM states: S_IDLE, S_ID, S_HI, S_LO, S_CHK. States advance only on cycles where i_rx_valid = 1.
  - S_IDLE: a byte equal to HEADER moves to S_ID. Any other byte is discarded silently (no error).
  - S_ID: latch ID, move to S_HI.
  - S_HI: latch high byte, move to S_LO.
  - S_LO: latch low byte, move to S_CHK.
  - S_CHK: evaluate the frame and return to S_IDLE.
- No resync inside a frame: a HEADER byte received in S_ID..S_CHK is treated as ordinary data.
- Accept, on the S_CHK valid cycle:
  - slot[ID] <= {UDC_HI, UDC_LO} and fresh bit ID-1 <= 1, both visible on the next cycle.
  - o_frame_ok pulses high for that next cycle only.
  - Latency from the CHK byte strobe to the bus update is 1 clock.
  - All other slots hold their values.
- Reject (bad checksum or ID outside 1..N_MOD):
  - No slot write and no fresh-mask change.
  - o_frame_err pulses for one cycle, 1 clock after the CHK strobe.
  - o_err_cnt increments, saturating at 16'hFFFF.
- Timeout:
  - In S_ID..S_CHK the counter increments every cycle without i_rx_valid and resets to 0 on each valid byte.
  - When it reaches TIMEOUT_CYC: FSM goes to S_IDLE, partial frame discarded, o_frame_err pulses, o_err_cnt increments (saturating), counter returns to 0.
  - The counter is held at 0 in S_IDLE.
- Fresh mask:
  - i_clear_fresh clears all bits.
  - If a frame is accepted in the same cycle, the clear applies first and that module's bit is then set (set wins for that bit).
- o_all_fresh is combinational from the registered o_fresh_mask.
- Udc values are passed through unsigned and unscaled; the block applies no clamping.
- Reset asserted mid-frame: state, slots and counters return immediately to reset values. The partial frame is lost, and no ok or err pulse is generated.

Test Plan:
- Reset, then bytes A5,01,0C,80,8D -> one cycle after the 8D strobe: o_LinkUdc_BUS[383:368] = 16'h0C80, o_frame_ok pulses once, o_fresh_mask = 24'h000001, all other slots 0.
- Bytes A5,18,12,34,5E -> o_LinkUdc_BUS[15:0] = 16'h1234, fresh bit 23 set. Then frames for IDs 2..23 -> o_all_fresh = 1. Then i_clear_fresh -> mask = 0 while bus values are retained.
- Bytes A5,03,01,00,00 (bad checksum) and A5,00,01,00,01 (ID 0) -> two o_frame_err pulses, o_err_cnt = 2, bus unchanged, no ok pulse.
- Bytes A5,02, then 5000 idle clocks -> o_frame_err pulse at timeout, FSM back in S_IDLE. Then A5,02,0A,00,0C -> slot 2 = 16'h0A00 accepted.
- Garbage 00,FF,13 before A5,05,00,64,69 -> no err pulses, slot 5 = 16'h0064. i_clear_fresh on the same cycle as the ok write -> mask = bit 4 only.
- Drop i_reset_n after A5,07,11 -> all outputs 0 immediately. After release, A5,07,11,22,3A -> slot 7 = 16'h1122. Also force 65536 errors -> o_err_cnt holds 16'hFFFF.
